booth16_mul_seq: RTL

- Parametrised, iterative radix-16 Booth multiplier for signed or unsigned W-bit fixed-point operands.
- Successor to the combinational 8-bit radix-16 compute unit. Uses the same scheme: odd multiples 1X/3X/5X/7X are precomputed, even magnitudes are formed by shifting them, and sign is applied by invert+1.
- Retires one Booth digit per cycle into a 2W-bit accumulator.
- Sits between the operand FIFO and the MAC writeback stage, with valid/ready on both sides.

---
 rtl/booth16_mul_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/booth16_mul_seq.sv
// Iterative radix-16 Booth multiplier that retires one digit per cycle into a 2W-bit accumulator.
// Optional early termination is enabled by the BOOTH16_MUL_SEQ_EARLY_TERM_EN macro.
module booth16_mul_seq #(
  parameter int W = 8
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iValid,
  output logic           oReady,
  input  logic           iUnsigned,
  input  logic [W-1:0]   iDatA,
  input  logic [W-1:0]   iDatB,
  output logic           oValid,
  input  logic           iReady,
  output logic [2*W-1:0] oDat,
  output logic           oBusy
);

  localparam int D  = (W + 4) / 4;
  localparam int MW = 4 * D + 1;
  localparam int IW = $clog2(D + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRECOMP = 2'd1,
    S_ITER    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic                  r_uns;
  logic signed [W+3:0]   r_x1;
  logic signed [W+3:0]   r_x3;
  logic signed [W+3:0]   r_x5;
  logic signed [W+3:0]   r_x7;
  logic [2*W-1:0]        r_acc;
  logic [MW-1:0]         r_mul;
  logic [IW-1:0]         r_idx;

  logic signed [W+3:0]   w_ax;
  logic [4*D-1:0]        w_bext;
  logic signed [4:0]     w_dig;
  logic                  w_neg;
  logic [4:0]            w_mag;
  logic signed [W+3:0]   w_sel;
  logic signed [W+3:0]   w_pp;
  logic signed [2*W-1:0] w_pp_ext;
  logic [IW+1:0]         w_sh;
  logic [MW-1:0]         w_mul_shift;
  logic                  w_last;
  logic                  w_early;

  assign w_ax   = r_uns ? {4'b0000, r_a} : {{4{r_a[W-1]}}, r_a};
  assign w_bext = r_uns ? {{(4*D-W){1'b0}}, r_b} : {{(4*D-W){r_b[W-1]}}, r_b};

  // The low 5 bits hold b3..b0 plus b[-1]; the signed nibble plus b[-1] is the digit.
  assign w_dig = $signed({r_mul[4], r_mul[4:1]}) + $signed({4'b0000, r_mul[0]});
  assign w_neg = w_dig[4];
  assign w_mag = w_neg ? -w_dig : w_dig;

  // Select the digit magnitude from the precomputed odd multiples.
  always_comb begin
    w_sel = '0;
    case (w_mag)
      5'd0:    w_sel = '0;
      5'd1:    w_sel = r_x1;
      5'd2:    w_sel = r_x1 <<< 1;
      5'd3:    w_sel = r_x3;
      5'd4:    w_sel = r_x1 <<< 2;
      5'd5:    w_sel = r_x5;
      5'd6:    w_sel = r_x3 <<< 1;
      5'd7:    w_sel = r_x7;
      5'd8:    w_sel = r_x1 <<< 3;
      default: w_sel = '0;
    endcase
  end

  assign w_pp        = w_neg ? (~w_sel + (W+4)'(1)) : w_sel;
  assign w_pp_ext    = w_pp;
  assign w_sh        = {r_idx, 2'b00};
  assign w_mul_shift = {{4{r_mul[MW-1]}}, r_mul[MW-1:4]};
  assign w_last      = (r_idx == IW'(D - 1));

`ifdef BOOTH16_MUL_SEQ_EARLY_TERM_EN
  // Remaining bits all equal means every remaining digit is zero.
  assign w_early = (w_mul_shift == '0) || (&w_mul_shift);
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    oReady      = 1'b0;
    oValid      = 1'b0;
    oBusy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
        if (iValid) begin
          w_state_nxt = S_PRECOMP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRECOMP: begin
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        if (w_last || w_early) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ITER;
        end
      end
      S_DONE: begin
        oValid = 1'b1;
        if (iReady) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        oBusy       = 1'b0;
      end
    endcase
  end

  // Operand capture, multiple precompute and digit accumulation.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_uns <= 1'b0;
      r_x1  <= '0;
      r_x3  <= '0;
      r_x5  <= '0;
      r_x7  <= '0;
      r_acc <= '0;
      r_mul <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iValid) begin
            r_a   <= iDatA;
            r_b   <= iDatB;
            r_uns <= iUnsigned;
          end
        end
        S_PRECOMP: begin
          r_x1  <= w_ax;
          r_x3  <= w_ax + (w_ax <<< 1);
          r_x5  <= w_ax + (w_ax <<< 2);
          r_x7  <= (w_ax <<< 3) - w_ax;
          r_acc <= '0;
          r_mul <= {w_bext, 1'b0};
          r_idx <= '0;
        end
        S_ITER: begin
          r_acc <= r_acc + (w_pp_ext << w_sh);
          r_mul <= w_mul_shift;
          r_idx <= r_idx + IW'(1);
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign oDat = r_acc;

endmodule
